// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common data bus (CDB) between out-of-order
// functional units. Each unit hands its result to a one-entry holding slot;
// a round-robin arbiter picks one held slot per cycle and drives it onto the
// registered CDB. A mispredict flush empties every holding slot.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-low
//   flush         discard all held results and transfers presented this cycle
//   req_valid     unit i has a completed result
//   req_rob_entry destination ROB entry of unit i
//   req_data      result data of unit i
//   req_ready     slot i accepts this cycle (combinational, valid-independent)
//   cdb_en        CDB carries a valid broadcast (registered)
//   cdb           broadcast payload {rob_entry, rd_data} (registered)
//   cdb_src       index of the requester being broadcast (registered)
//
// NUM_REQ must be at least 2.

package cdb_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_W     = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [ROB_W-1:0] rob_entry;
    logic [31:0]      rd_data;
  } cdb_t;
endpackage

module cdb_arbiter #(
  parameter int  NUM_REQ   = 4,
  parameter int  ROB_DEPTH = cdb_pkg::ROB_DEPTH,
  localparam int ROB_W     = $clog2(ROB_DEPTH),
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ROB_W-1:0]   req_rob_entry,
  input  logic [NUM_REQ-1:0][31:0]        req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            cdb_en,
  output cdb_pkg::cdb_t                   cdb,
  output logic [SRC_W-1:0]                cdb_src
);

  logic [NUM_REQ-1:0]            r_hold_v;
  logic [NUM_REQ-1:0][ROB_W-1:0] r_hold_rob;
  logic [NUM_REQ-1:0][31:0]      r_hold_data;
  logic [SRC_W-1:0]              r_rr_ptr;
  logic                          r_cdb_en;
  cdb_pkg::cdb_t                 r_cdb;
  logic [SRC_W-1:0]              r_cdb_src;

  logic                          w_grant_v;
  logic [SRC_W-1:0]              w_grant_idx;
  logic [SRC_W-1:0]              w_next_ptr;
  logic [NUM_REQ-1:0]            w_grant;
  logic [NUM_REQ-1:0]            w_ready;
  logic [NUM_REQ-1:0]            w_accept;

  // Round-robin search starting at r_rr_ptr. The scan runs from the farthest
  // offset to the nearest, so the nearest held slot is the last one written.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_grant_v   = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (r_hold_v[SRC_W'(idx)]) begin
        w_grant_v   = 1'b1;
        w_grant_idx = SRC_W'(idx);
      end
    end
  end

  assign w_grant    = w_grant_v ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign w_next_ptr = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0
                                                           : w_grant_idx + SRC_W'(1);

  // A slot draining this cycle can be refilled on the same edge, which gives a
  // lone streaming unit one broadcast per cycle.
  assign w_ready  = ~r_hold_v | w_grant;
  assign w_accept = req_valid & w_ready;

  // Control state: reset takes priority over flush, flush over normal operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      r_hold_v  <= '0;
      r_rr_ptr  <= '0;
      r_cdb_en  <= 1'b0;
      r_cdb     <= '0;
      r_cdb_src <= '0;
    end else if (flush) begin
      // Transfers presented this cycle are dropped; rr_ptr and the last
      // payload are left alone.
      r_hold_v <= '0;
      r_cdb_en <= 1'b0;
    end else begin
      // A refill on the granted slot wins over the clear.
      r_hold_v <= (r_hold_v & ~w_grant) | w_accept;
      r_cdb_en <= w_grant_v;
      if (w_grant_v) begin
        r_cdb.rob_entry <= r_hold_rob[w_grant_idx];
        r_cdb.rd_data   <= r_hold_data[w_grant_idx];
        r_cdb_src       <= w_grant_idx;
        r_rr_ptr        <= w_next_ptr;
      end
    end
  end

  // NOTE: the payload storage has no reset; it is only ever read while the
  // matching r_hold_v bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept[i]) begin
        r_hold_rob[i]  <= req_rob_entry[i];
        r_hold_data[i] <= req_data[i];
      end
    end
  end

  assign req_ready = w_ready;
  assign cdb_en    = r_cdb_en;
  assign cdb       = r_cdb;
  assign cdb_src   = r_cdb_src;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the functional units (ALU, branch, load/store, mul/div) that complete out of order.
- Each requester hands its result to a one-entry holding slot.
- A round-robin arbiter picks one holding slot per cycle and drives it onto the registered CDB.
- The CDB feeds reservation-station wakeup, the ROB and operand-capture logic.
- Mispredict flush empties all pending results.

Parameters:
- NUM_REQ, 4, number of functional-unit requesters; must be ≥2.
- ROB_DEPTH, 8, ROB entries; ROB_W = $clog2(ROB_DEPTH).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- flush  input  1  pipeline flush; discards all held and in-flight results.
- req_valid  input  [NUM_REQ]  unit i has a completed result.
- req_rob_entry  input  [NUM_REQ][ROB_W]  destination ROB entry of unit i.
- req_data  input  [NUM_REQ][32]  result data of unit i.
- req_ready  output  [NUM_REQ]  slot i can accept this cycle; combinational.
- cdb_en  output  1  CDB carries a valid broadcast.
- cdb  output  cdb_t  broadcast payload (rob_entry, rd_data); registered.
- cdb_src  output  [$clog2(NUM_REQ)]  index of the requester being broadcast; registered.

Behaviour:
- State:
  - Per requester: hold_v[i], hold_rob[i], hold_data[i].
  - Round-robin pointer rr_ptr, range 0..NUM_REQ-1.
  - Output registers cdb_en, cdb, cdb_src.
- Reset (rst==0 at posedge):
  - hold_v all 0; rr_ptr=0; cdb_en=0; cdb='0; cdb_src=0.
  - Reset wins over every other event, including mid-burst; all held results are lost.
- Handshake:
  - req_ready[i] = !hold_v[i] || grant[i].
  - A transfer occurs at a posedge when req_valid[i] && req_ready[i].
  - Requester must hold its payload stable while req_valid && !req_ready.
  - req_ready is independent of req_valid (no combinational loop).
- Arbitration (combinational, each cycle):
  - Among slots with hold_v==1, grant the first index found searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - At most one grant per cycle. No hold_v set → no grant.
- On posedge with a grant g (and no flush):
  - cdb_en<=1; cdb.rob_entry<=hold_rob[g]; cdb.rd_data<=hold_data[g]; cdb_src<=g.
  - rr_ptr<=(g+1) mod NUM_REQ.
  - hold_v[g] cleared unless refilled on the same edge (back-to-back: refill wins, new payload captured).
- No grant: cdb_en<=0; cdb and cdb_src keep their previous values; rr_ptr unchanged.
- Latency: a result accepted at edge k is broadcast (cdb_en high) no earlier than after edge k+1. No bypass from req to cdb.
- Throughput:
  - One broadcast per cycle overall.
  - A single requester streaming alone gets a broadcast every cycle.
  - Under full contention each requester is served at least once every NUM_REQ cycles (no starvation).
- Flush (flush==1, rst==1):
  - All hold_v<=0; cdb_en<=0.
  - Transfers presented that cycle are dropped; req_ready reports normally.
  - rr_ptr unchanged.
  - A broadcast already registered before the flush edge stays visible for its cycle.
- Full condition: a slot with hold_v==1 and not granted deasserts req_ready; the unit must stall.
- Empty condition: all hold_v==0 → cdb_en=0 next cycle.
- rob_entry values are carried unmodified. No duplicate-ROB check; the ROB guarantees uniqueness.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release with no requests → cdb_en=0, req_ready=4'b1111, cdb_src=0 on every cycle.
- Single request: unit 2 sends rob=5, data=0xDEADBEEF for 1 cycle → cdb_en=1 exactly one cycle after the accept edge with cdb={5,0xDEADBEEF}, cdb_src=2; then cdb_en=0.
- Full contention: all 4 units assert continuously from rr_ptr=0 with rob=i, data=0x100+i → cdb_src sequence 0,1,2,3,0,... with cdb_en=1 every cycle; each req_ready pulses only in its grant cycle.
- Back-to-back stream: unit 1 alone streams rob 0..7 with data=rob*3 → eight consecutive broadcasts, in order, no bubbles.
- Flush: units 0 and 3 hold results, assert flush one cycle → next cycle cdb_en=0, all hold_v cleared; a new unit-3 request afterwards is broadcast normally.
- Reset mid-operation: 3 slots held, rst=0 for one cycle → cdb_en=0 and req_ready=4'b1111 on the following cycle; no stale broadcast afterwards.
